// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared CPU bus types and widths
package nes_bus_pkg;

    localparam int CPU_RAM_ADDR_W = 11;
    localparam int CPU_DATA_W     = 8;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD_WAIT,
        RD_ACK,
        WR_ACK
    } ram_state_t;

endpackage

// File: rtl/cpu_ram_bram.sv
// rtl/cpu_ram_bram.sv - single-port write-first block RAM, registered read
module cpu_ram_bram
    import nes_bus_pkg::*;
#(
    parameter int ADDR_W = CPU_RAM_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset on purpose: contents are only cleared by the controller's sweep.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= din;
                dout     <= din;
            end else begin
                dout <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/cpu_ram_ctrl.sv
// rtl/cpu_ram_ctrl.sv - CPU work RAM responder with mirroring and post-reset clear
module cpu_ram_ctrl
    import nes_bus_pkg::*;
#(
    parameter int ADDR_W         = CPU_RAM_ADDR_W,
    parameter int DATA_W         = CPU_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       addr,
    input  logic              ramSel,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy
);

    localparam ram_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    ram_state_t        state, state_n;
    logic [ADDR_W:0]   clr_cnt, clr_nxt;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [DATA_W-1:0] ram_din, ram_dout;

    // Upper address bits only select the mirror; they never reach storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[15:ADDR_W];

    assign clr_nxt = clr_cnt + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_n = state;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        ram_idx = addr[ADDR_W-1:0];
        ram_din = wdata;
        case (state)
            CLEAR: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                ram_idx = clr_cnt[ADDR_W-1:0];
                ram_din = '0;
                // Carry into the extra bit marks the write of the last index.
                if (clr_nxt[ADDR_W]) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (req && ramSel) begin
                    ram_en  = 1'b1;
                    ram_we  = we;
                    state_n = we ? WR_ACK : RD_WAIT;
                end
            end
            RD_WAIT: state_n = RD_ACK;
            RD_ACK:  state_n = IDLE;
            WR_ACK:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
            busy    <= CLEAR_ON_RESET;
        end else begin
            state <= state_n;
            ack   <= (state_n == RD_ACK) || (state_n == WR_ACK);
            busy  <= (state_n == CLEAR);
            if (state == CLEAR) begin
                clr_cnt <= clr_nxt;
            end
            if (state == RD_WAIT) begin
                rdata <= ram_dout;
            end
        end
    end

    cpu_ram_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .idx  (ram_idx),
        .din  (ram_din),
        .dout (ram_dout)
    );

endmodule
